// File: rtl/jstk2_axil_slave_regs.sv
// AXI4-Lite slave register file for the PmodJSTK2: four RW control words feed the SPI engine,
// and four RO status words capture its joystick samples.
module jstk2_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic [9:0]                      jstk_x,
    input  logic [9:0]                      jstk_y,
    input  logic [2:0]                      jstk_btn,
    input  logic                            jstk_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    output logic [23:0]                     led_rgb
);
    typedef logic [C_S_AXI_DATA_WIDTH-1:0]   word_t;
    typedef logic [C_S_AXI_DATA_WIDTH/8-1:0] strb_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    w_state_e   w_state_q, w_state_d;
    r_state_e   r_state_q, r_state_d;
    logic       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    logic       aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [2:0] awidx_q, awidx_d;
    word_t      wdata_q, wdata_d;
    strb_t      wstrb_q, wstrb_d;
    logic       arready_q, arready_d, rvalid_q, rvalid_d;
    word_t      rdata_q, rdata_d;
    word_t      regs_q [8];
    word_t      regs_d [8];

    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        regs_d    = regs_q;

        // AW and W are captured independently; the write fires once both halves are held.
        case (w_state_q)
            W_IDLE: begin
                if (s00_axi_awvalid && awready_q) begin
                    aw_full_d = 1'b1;
                    awidx_d   = s00_axi_awaddr[4:2];
                end
                if (s00_axi_wvalid && wready_q) begin
                    w_full_d = 1'b1;
                    wdata_d  = s00_axi_wdata;
                    wstrb_d  = s00_axi_wstrb;
                end
                awready_d = !aw_full_d;
                wready_d  = !w_full_d;
                if (aw_full_d && w_full_d) begin
                    if (!awidx_d[2]) begin
                        for (int i = 0; i < C_S_AXI_DATA_WIDTH / 8; i++) begin
                            if (wstrb_d[i]) regs_d[awidx_d][8*i +: 8] = wdata_d[8*i +: 8];
                        end
                    end
                    bresp_d   = awidx_d[2] ? RESP_SLVERR : RESP_OKAY;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // Reads sample regs_q, so a same-cycle write to the same word returns the old value.
        case (r_state_q)
            R_IDLE: begin
                if (s00_axi_arvalid && arready_q) begin
                    rdata_d   = regs_q[s00_axi_araddr[4:2]];
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        if (jstk_valid) begin
            regs_d[4] = word_t'(jstk_x);
            regs_d[5] = word_t'(jstk_y);
            regs_d[6] = word_t'(jstk_btn);
            regs_d[7] = regs_q[7] + word_t'(1);
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (s00_axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            // NOTE: the register array is only eight words and must read back as zero, so it is reset.
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign ctrl_out        = regs_q[0];
    assign led_rgb         = regs_q[1][23:0];

endmodule

// File: tb/tb_jstk2_axil_slave_regs.sv
// Randomised self-checking bench for jstk2_axil_slave_regs against a word-array reference model.
module tb_jstk2_axil_slave_regs;
    logic        clk = 1'b0;
    logic        areset;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata, ctrl_out;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [9:0]  jstk_x, jstk_y;
    logic [2:0]  jstk_btn;
    logic        jstk_valid;
    logic [23:0] led_rgb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [8];

    always #5 clk = ~clk;

    jstk2_axil_slave_regs dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .jstk_x(jstk_x), .jstk_y(jstk_y), .jstk_btn(jstk_btn), .jstk_valid(jstk_valid),
        .ctrl_out(ctrl_out), .led_rgb(led_rgb)
    );

    // Reference model: RW words take the strobed bytes, RO words reject the write with SLVERR.
    function automatic logic [1:0] model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int w = int'(addr) / 4;
        if (w >= 4) return 2'b10;
        for (int i = 0; i < 4; i++) if (strb[i]) model[w][8*i +: 8] = data[8*i +: 8];
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        model_clear();
    endtask

    task automatic pulse_jstk(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn);
        jstk_x = x; jstk_y = y; jstk_btn = btn; jstk_valid = 1'b1;
        @(negedge clk);
        jstk_valid = 1'b0;
        model[4] = {22'b0, x};
        model[5] = {22'b0, y};
        model[6] = {29'b0, btn};
        model[7] = model[7] + 32'd1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
            if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1; wvalid = 1'b0; end
            if (aw_done && !w_done) begin
                n_checks++;
                if (awready !== 1'b0) begin n_fail++; $display("FAIL awready_after_aw: got %b want 0", awready); end
            end
            if (w_done && !aw_done) begin
                n_checks++;
                if (wready !== 1'b0) begin n_fail++; $display("FAIL wready_after_w: got %b want 0", wready); end
            end
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++;
        if (!(aw_done && w_done)) begin n_fail++; $display("FAIL write_handshake_timeout addr=%h", addr); return; end
        n_checks++;
        if (bvalid !== 1'b1) begin n_fail++; $display("FAIL bvalid_latency: got %b want 1", bvalid); end
        cyc = 0;
        while (bvalid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        for (int i = 0; i < b_dly; i++) begin
            n_checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                n_fail++; $display("FAIL b_hold: bvalid=%b awready=%b wready=%b want 1/0/0", bvalid, awready, wready);
            end
            @(negedge clk);
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++; $display("FAIL b_done: bvalid=%b awready=%b wready=%b want 0/1/1", bvalid, awready, wready);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, input int r_dly, output logic [31:0] data, output logic [1:0] resp);
        bit hs = 0;
        int cyc = 0;
        data = 'x; resp = 'x;
        arvalid = 1'b1; araddr = addr;
        while (cyc < 50) begin
            hs = arready;
            @(posedge clk);
            @(negedge clk);
            if (hs) break;
            cyc++;
        end
        arvalid = 1'b0;
        n_checks++;
        if (!hs) begin n_fail++; $display("FAIL read_handshake_timeout addr=%h", addr); return; end
        n_checks++;
        if (rvalid !== 1'b1 || arready !== 1'b0) begin
            n_fail++; $display("FAIL r_latency: rvalid=%b arready=%b want 1/0", rvalid, arready);
        end
        repeat (r_dly) @(negedge clk);
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++; $display("FAIL r_done: rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0 || rvalid !== 1'b0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 || ctrl_out !== 32'h0 || led_rgb !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state: awr=%b wr=%b arr=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h ctrl=%h led=%h want 1 1 1 0 0 00 00 0 0 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, ctrl_out, led_rgb);
        end
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, r);
            void'(model_write(5'(4 * i), 32'(i + 1), 4'hF));
            n_checks++;
            if (r !== 2'b00) begin n_fail++; $display("FAIL basic_bresp word%0d: got %b want 00", i, r); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 0, d, r);
            n_checks++;
            if (d !== model[i] || r !== 2'b00) begin
                n_fail++; $display("FAIL basic_read word%0d: got %h/%b want %h/00", i, d, r, model[i]);
            end
        end
        n_checks++;
        if (ctrl_out !== 32'd1 || led_rgb !== 24'd2) begin
            n_fail++; $display("FAIL basic_outputs: ctrl=%h led=%h want 1/2", ctrl_out, led_rgb);
        end
    endtask

    task automatic test_channel_order();
        logic [1:0] r; logic [31:0] d;
        axi_write(5'h08, 32'hA5A5_0001, 4'hF, 0, 3, 0, r);
        void'(model_write(5'h08, 32'hA5A5_0001, 4'hF));
        axi_write(5'h0C, 32'h5A5A_0002, 4'hF, 3, 0, 0, r);
        void'(model_write(5'h0C, 32'h5A5A_0002, 4'hF));
        for (int i = 2; i < 4; i++) begin
            axi_read(5'(4 * i), 1, d, r);
            n_checks++;
            if (d !== model[i]) begin n_fail++; $display("FAIL order_read word%0d: got %h want %h", i, d, model[i]); end
        end
    endtask

    task automatic test_bready_hold();
        logic [1:0] r;
        axi_write(5'h00, 32'h0000_0011, 4'hF, 0, 0, 5, r);
        void'(model_write(5'h00, 32'h0000_0011, 4'hF));
        n_checks++;
        if (r !== 2'b00 || ctrl_out !== model[0]) begin
            n_fail++; $display("FAIL bready_hold: bresp=%b ctrl=%h want 00/%h", r, ctrl_out, model[0]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [31:0] d;
        axi_write(5'h04, 32'h0, 4'hF, 0, 0, 0, r);
        void'(model_write(5'h04, 32'h0, 4'hF));
        axi_write(5'h04, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, r);
        void'(model_write(5'h04, 32'hFFFF_FFFF, 4'b0101));
        axi_read(5'h04, 0, d, r);
        n_checks++;
        if (d !== 32'h00FF_00FF || led_rgb !== 24'hFF_00FF) begin
            n_fail++; $display("FAIL strobe_0101: word1=%h led=%h want 00ff00ff/ff00ff", d, led_rgb);
        end
        axi_write(5'h04, 32'h1234_5678, 4'b0000, 0, 0, 0, r);
        axi_read(5'h05, 0, d, r);
        n_checks++;
        if (d !== 32'h00FF_00FF) begin n_fail++; $display("FAIL strobe_0000: got %h want 00ff00ff", d); end
    endtask

    task automatic test_status();
        logic [1:0] r; logic [31:0] d;
        @(negedge clk);
        pulse_jstk(10'h3FF, 10'h155, 3'b101);
        for (int i = 4; i < 8; i++) begin
            axi_read(5'(4 * i), 0, d, r);
            n_checks++;
            if (d !== model[i] || r !== 2'b00) begin
                n_fail++; $display("FAIL status_read word%0d: got %h/%b want %h/00", i, d, r, model[i]);
            end
        end
        n_checks++;
        if (model[7] !== 32'd1) begin n_fail++; $display("FAIL status_count_model: got %h want 1", model[7]); end
    endtask

    task automatic test_slverr();
        logic [1:0] r; logic [31:0] d;
        axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL slverr_bresp: got %b want 10", r); end
        axi_read(5'h10, 0, d, r);
        n_checks++;
        if (d !== 32'h0000_03FF) begin n_fail++; $display("FAIL slverr_word4: got %h want 000003ff", d); end
    endtask

    task automatic test_same_cycle();
        logic [1:0] wr, rr; logic [31:0] d, old;
        old = model[2];
        fork
            axi_write(5'h08, 32'hCAFE_F00D, 4'hF, 0, 0, 0, wr);
            axi_read(5'h08, 0, d, rr);
        join
        void'(model_write(5'h08, 32'hCAFE_F00D, 4'hF));
        n_checks++;
        if (d !== old) begin n_fail++; $display("FAIL same_cycle_old: got %h want %h", d, old); end
        axi_read(5'h08, 0, d, rr);
        n_checks++;
        if (d !== model[2]) begin n_fail++; $display("FAIL same_cycle_new: got %h want %h", d, model[2]); end
    endtask

    task automatic test_status_during_read();
        logic [1:0] r; logic [31:0] d, old;
        old = model[4];
        fork
            axi_read(5'h10, 4, d, r);
            begin @(negedge clk); pulse_jstk(10'h0AA, 10'h011, 3'b010); end
        join
        n_checks++;
        if (d !== old) begin n_fail++; $display("FAIL status_latched: got %h want %h", d, old); end
        axi_read(5'h1C, 0, d, r);
        n_checks++;
        if (d !== model[7]) begin n_fail++; $display("FAIL status_count: got %h want %h", d, model[7]); end
    endtask

    task automatic test_random();
        logic [1:0] r, exp_r; logic [31:0] d, data; logic [3:0] strb; logic [4:0] a;
        for (int n = 0; n < 60; n++) begin
            a = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: begin
                    data = $urandom;
                    strb = 4'($urandom_range(0, 15));
                    axi_write(a, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
                    exp_r = model_write(a, data, strb);
                    n_checks++;
                    if (r !== exp_r || ctrl_out !== model[0] || led_rgb !== model[1][23:0]) begin
                        n_fail++;
                        $display("FAIL rand_write a=%h: bresp=%b ctrl=%h led=%h want %b/%h/%h", a, r, ctrl_out, led_rgb, exp_r, model[0], model[1][23:0]);
                    end
                end
                1: begin
                    axi_read(a, $urandom_range(0, 3), d, r);
                    n_checks++;
                    if (d !== model[int'(a) / 4] || r !== 2'b00) begin
                        n_fail++; $display("FAIL rand_read a=%h: got %h/%b want %h/00", a, d, r, model[int'(a) / 4]);
                    end
                end
                default: pulse_jstk(10'($urandom), 10'($urandom), 3'($urandom));
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [31:0] d;
        axi_write(5'h00, 32'h0000_00F1, 4'hF, 0, 0, 0, r);
        @(negedge clk);
        arvalid = 1'b1; araddr = 5'h00;
        awvalid = 1'b1; awaddr = 5'h04;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL reset_mid_setup: rvalid=%b want 1", rvalid); end
        areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1 || ctrl_out !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mid_idle: rv=%b bv=%b arr=%b awr=%b wr=%b ctrl=%h want 0 0 1 1 1 0", rvalid, bvalid, arready, awready, wready, ctrl_out);
            end
            @(negedge clk);
        end
        axi_read(5'h00, 0, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mid_word0: got %h want 0", d); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        jstk_x = '0; jstk_y = '0; jstk_btn = '0; jstk_valid = 1'b0;
        model_clear();
        do_reset();
        test_reset();
        test_basic();
        test_channel_order();
        test_bready_hold();
        test_strobe();
        test_status();
        test_slverr();
        test_same_cycle();
        test_status_during_read();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
